// File: rtl/fifo_io_pkg.sv
// Shared constants and types for the narrow/wide FIFO I/O path (aggregator / disaggregator).
// Holds the default narrow word size, the fetch ratio, the frame-counter width and the state type.
// Other files in this path import it; it contains no logic of its own.
package fifo_io_pkg;

    localparam int DSIZE         = 11;
    localparam int FETCH_WIDTH   = 2;
    localparam int STORAGE_WIDTH = DSIZE * FETCH_WIDTH;
    localparam int FCNT_WIDTH    = 16;

    typedef logic [$clog2(FETCH_WIDTH)-1:0] beat_t;
    typedef logic [FCNT_WIDTH-1:0]          fcnt_t;

    // IDLE: nothing held; SEND: holding register is valid.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } dstate_t;

endpackage

// File: rtl/frame_counter.sv
// Frame tracking for the disaggregator: counts completed wide words and flags the frame's final narrow word.
// Ports: frame_len_i (sampled at frame start), load_i (upstream pop), word_done_i (last-beat enqueue),
//        valid_i/last_beat_i (holding state), receiver_last_o (combinational), frame_done_o (registered pulse).
module frame_counter
    import fifo_io_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 wrst_n,
    input  logic [CNT_WIDTH-1:0] frame_len_i,
    input  logic                 load_i,
    input  logic                 valid_i,
    input  logic                 last_beat_i,
    input  logic                 word_done_i,
    output logic                 receiver_last_o,
    output logic                 frame_done_o
);

    logic [CNT_WIDTH-1:0] wcnt_q, wcnt_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic                 frame_done_q, frame_done_d;

    // len_q==0 means unframed: the subtraction wraps but the len_q!=0 term masks it.
    assign receiver_last_o = valid_i && (len_q != '0) && last_beat_i
                             && (wcnt_q == len_q - CNT_WIDTH'(1));
    assign frame_done_o    = frame_done_q;

    always_comb begin
        wcnt_d       = wcnt_q;
        len_d        = len_q;
        frame_done_d = 1'b0;
        if (word_done_i) begin
            wcnt_d       = receiver_last_o ? '0 : wcnt_q + CNT_WIDTH'(1);
            frame_done_d = receiver_last_o;
        end
        // Judge "frame start" on the post-update count so that a prefetch coinciding
        // with the previous frame's last word samples the new length, while a prefetch
        // of the second word (count still 0 before this edge) does not re-sample.
        if (load_i && (wcnt_d == '0)) begin
            len_d = frame_len_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!wrst_n) begin
            wcnt_q       <= '0;
            len_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            wcnt_q       <= wcnt_d;
            len_q        <= len_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: rtl/disaggregator.sv
// Splits each wide word popped from an upstream FWFT FIFO into FETCH_WIDTH narrow words, LSB slice first.
// Latency: first narrow enqueue one cycle after the pop; last-beat prefetch sustains one word per cycle.
// Backpressure: receiver_full_n low freezes beat, hold and receiver_data; no enqueue and no pop occur.
module disaggregator #(
    parameter int DATA_WIDTH  = fifo_io_pkg::DSIZE,
    parameter int FETCH_WIDTH = fifo_io_pkg::FETCH_WIDTH,
    parameter int CNT_WIDTH   = fifo_io_pkg::FCNT_WIDTH
) (
    input  logic                              clk,
    input  logic                              wrst_n,
    input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
    input  logic                              sender_empty_n,
    output logic                              sender_deq,
    output logic [DATA_WIDTH-1:0]             receiver_data,
    input  logic                              receiver_full_n,
    output logic                              receiver_enq,
    input  logic [CNT_WIDTH-1:0]              frame_len,
    output logic                              receiver_last,
    output logic                              frame_done,
    output logic                              busy
);
    import fifo_io_pkg::*;

    localparam int            BW        = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int            WW        = FETCH_WIDTH * DATA_WIDTH;
    localparam logic [BW-1:0] LAST_BEAT = BW'(FETCH_WIDTH - 1);

    dstate_t       state_q, state_d;
    logic [WW-1:0] hold_q, hold_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          valid_q;
    logic          last_beat;
    logic          word_done;

    assign valid_q   = (state_q == ST_SEND);
    assign last_beat = (beat_q == LAST_BEAT);

    // Both handshakes are held off while reset is asserted so that no upstream word
    // is popped and no stale beat is pushed during the reset cycle itself.
    assign receiver_enq  = wrst_n && valid_q && receiver_full_n;
    assign word_done     = receiver_enq && last_beat;
    assign sender_deq    = wrst_n && sender_empty_n && (!valid_q || word_done);
    assign receiver_data = hold_q[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH];
    assign busy          = valid_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        beat_d  = beat_q;
        if (sender_deq) begin
            // Covers both the idle load and the last-beat prefetch.
            hold_d  = sender_data;
            beat_d  = '0;
            state_d = ST_SEND;
        end else if (receiver_enq) begin
            if (!last_beat) begin
                beat_d = beat_q + BW'(1);
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!wrst_n) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            beat_q  <= beat_d;
        end
    end

    frame_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_frame_counter (
        .clk             (clk),
        .wrst_n          (wrst_n),
        .frame_len_i     (frame_len),
        .load_i          (sender_deq),
        .valid_i         (valid_q),
        .last_beat_i     (last_beat),
        .word_done_i     (word_done),
        .receiver_last_o (receiver_last),
        .frame_done_o    (frame_done)
    );

endmodule

// File: tb/tb_disaggregator.sv
module tb_disaggregator;

    localparam int DW = 11;
    localparam int FW = 2;
    localparam int CW = 16;

    logic             clk;
    logic             wrst_n;
    logic [FW*DW-1:0] sender_data;
    logic             sender_empty_n;
    logic             sender_deq;
    logic [DW-1:0]    receiver_data;
    logic             receiver_full_n;
    logic             receiver_enq;
    logic [CW-1:0]    frame_len;
    logic             receiver_last;
    logic             frame_done;
    logic             busy;

    disaggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .wrst_n          (wrst_n),
        .sender_data     (sender_data),
        .sender_empty_n  (sender_empty_n),
        .sender_deq      (sender_deq),
        .receiver_data   (receiver_data),
        .receiver_full_n (receiver_full_n),
        .receiver_enq    (receiver_enq),
        .frame_len       (frame_len),
        .receiver_last   (receiver_last),
        .frame_done      (frame_done),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: upstream FIFO contents, narrow words still owed downstream,
    // and the position of the next narrow word within the current frame.
    logic [FW*DW-1:0] src_q[$];
    logic [DW-1:0]    exp_q[$];
    int               mlen;
    int               nidx;
    logic             exp_fd;
    int               rst_cyc;
    int               src_pct, dst_pct;
    int               vectors, errs;
    int               enq_cnt, deq_cnt, last_cnt, fd_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        sender_empty_n  = (src_q.size() > 0) && (int'($urandom_range(99)) < src_pct);
        sender_data     = (src_q.size() > 0) ? src_q[0] : (FW*DW)'($urandom);
        receiver_full_n = int'($urandom_range(99)) < dst_pct;
    endtask

    // One clock: check at the falling edge, advance the model, then drive the next inputs.
    task automatic tick();
        int               owed;
        logic             e_last;
        logic [FW*DW-1:0] w;
        @(negedge clk);
        if (!wrst_n) begin
            chk("rst_deq", sender_deq, 0);
            chk("rst_enq", receiver_enq, 0);
            if (rst_cyc > 0) begin
                chk("rst_busy", busy, 0);
                chk("rst_last", receiver_last, 0);
                chk("rst_fdone", frame_done, 0);
                chk("rst_data", receiver_data, 0);
            end
            rst_cyc++;
            exp_q.delete();
            nidx   = 0;
            exp_fd = 1'b0;
        end else begin
            rst_cyc = 0;
            owed    = exp_q.size();
            chk("frame_done", frame_done, exp_fd);
            if (frame_done) fd_cnt++;
            exp_fd = 1'b0;
            chk("busy", busy, owed > 0);
            chk("enq", receiver_enq, receiver_full_n && owed > 0);
            chk("deq", sender_deq, sender_empty_n && (owed == 0 || (receiver_full_n && owed == 1)));
            if (receiver_enq && owed > 0) begin
                chk("data", receiver_data, exp_q[0]);
                e_last = (mlen != 0) && (((nidx + 1) % (mlen * FW)) == 0);
                chk("last", receiver_last, e_last);
                exp_fd = e_last;
                if (e_last) last_cnt++;
                void'(exp_q.pop_front());
                nidx++;
                enq_cnt++;
            end else if (owed == 0) begin
                chk("idle_last", receiver_last, 0);
            end
            if (sender_deq && src_q.size() > 0) begin
                w = src_q.pop_front();
                for (int k = 0; k < FW; k++) exp_q.push_back(w[k*DW +: DW]);
                deq_cnt++;
            end
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        tick();
        tick();
        wrst_n = 1'b1;
    endtask

    task automatic drain(input string tag, input int limit);
        int n;
        n = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && n < limit) begin
            tick();
            n++;
        end
        chk(tag, (src_q.size() == 0) && (exp_q.size() == 0), 1);
    endtask

    initial begin
        int d0, e0, l0, f0;
        logic [FW*DW-1:0] wa;
        vectors = 0; errs = 0;
        enq_cnt = 0; deq_cnt = 0; last_cnt = 0; fd_cnt = 0;
        rst_cyc = 0; nidx = 0; exp_fd = 1'b0;
        mlen = 0; frame_len = '0;
        src_pct = 100; dst_pct = 100;
        wrst_n = 1'b0;
        drive();

        // Reset state
        do_reset();

        // Single word, LSB slice first
        src_q.push_back(22'h0C0401);
        drive();
        d0 = deq_cnt; e0 = enq_cnt;
        tick();
        #1 chk("single_b0", receiver_data, 11'h401);
        tick();
        #1 chk("single_b1", receiver_data, 11'h180);
        tick();
        #1 chk("single_busy_after", busy, 0);
        chk("single_deqs", deq_cnt - d0, 1);
        chk("single_enqs", enq_cnt - e0, 2);

        // Streaming: four words, one narrow word every cycle
        do_reset();
        for (int i = 0; i < 4; i++) src_q.push_back((FW*DW)'($urandom));
        drive();
        d0 = deq_cnt;
        tick();
        for (int i = 0; i < 8; i++) begin
            e0 = enq_cnt;
            tick();
            chk("stream_enq_per_cycle", enq_cnt - e0, 1);
        end
        chk("stream_deqs", deq_cnt - d0, 4);

        // Back-pressure after beat 0, with a second word waiting upstream
        do_reset();
        wa = (FW*DW)'($urandom);
        src_q.push_back(wa);
        src_q.push_back((FW*DW)'($urandom));
        drive();
        tick();
        dst_pct = 0;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_data_held", receiver_data, wa[DW +: DW]);
            chk("bp_no_enq", receiver_enq, 0);
            chk("bp_no_deq", sender_deq, 0);
            if (i == 2) dst_pct = 100;
            tick();
        end
        drain("bp_drain", 50);

        // Framing: three wide words per frame, six words; frame_len wiggled mid-frame
        mlen = 3; frame_len = 16'd3;
        do_reset();
        for (int i = 0; i < 6; i++) src_q.push_back((FW*DW)'($urandom));
        drive();
        l0 = last_cnt; f0 = fd_cnt;
        tick();
        frame_len = 16'd7;
        tick();
        tick();
        frame_len = 16'd3;
        for (int i = 0; i < 12; i++) tick();
        chk("frame_lasts", last_cnt - l0, 2);
        chk("frame_dones", fd_cnt - f0, 2);

        // Reset in the middle of a word: remainder dropped, next word starts at beat 0
        mlen = 0; frame_len = '0;
        do_reset();
        src_q.push_back((FW*DW)'($urandom));
        src_q.push_back((FW*DW)'($urandom));
        drive();
        tick();
        tick();
        e0 = enq_cnt;
        do_reset();
        chk("midrst_src_kept", src_q.size(), 1);
        drain("midrst_drain", 50);
        chk("midrst_enqs", enq_cnt - e0, 2);

        // Random stalls on both sides: 100 unframed words, then 100 words in 5-word frames
        src_pct = 60; dst_pct = 55;
        do_reset();
        e0 = enq_cnt;
        for (int i = 0; i < 100; i++) src_q.push_back((FW*DW)'($urandom));
        drain("rand_unframed_drain", 3000);
        chk("rand_unframed_enqs", enq_cnt - e0, 200);

        mlen = 5; frame_len = 16'd5;
        do_reset();
        e0 = enq_cnt; l0 = last_cnt;
        for (int i = 0; i < 100; i++) src_q.push_back((FW*DW)'($urandom));
        drain("rand_framed_drain", 3000);
        tick();
        chk("rand_framed_enqs", enq_cnt - e0, 200);
        chk("rand_framed_lasts", last_cnt - l0, 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
